// File: rtl/adc_i2c_sampler.sv
// adc_i2c_sampler
// Command sequencer upstream of a byte-oriented I2C master. It configures an
// external 12-bit ADC, sets its conversion pointer, then reads one conversion
// per sample tick and emits signed 12-bit samples with a one-cycle strobe.
// The master's busy line paces the sequence: the next byte is presented on
// each busy rising edge, and a transaction ends on the final busy falling edge.
//
// Optional build macro: ADC_DCBLOCK_EN inserts a first-order DC blocker after
// the raw sample. This adds one cycle of latency.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   enable          run request; low returns the block to idle
//   i2c_ena         command latch request to the master
//   i2c_addr        slave address (constant DEV_ADDR)
//   i2c_rw          0 = write, 1 = read
//   i2c_data_wr     byte to write
//   i2c_busy        master busy
//   i2c_data_rd     byte read by the master
//   i2c_ack_error   master NACK flag
//   sample          latest sample, two's complement
//   sample_valid    one-cycle strobe when sample updates
//   cfg_done        configuration and pointer writes succeeded
//   overrun         sticky: a tick arrived while one was still pending
//   error           high while in the error state
module adc_i2c_sampler #(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned SAMPLE_HZ   = 8000,
   parameter logic [6:0]  DEV_ADDR    = 7'h48,
   parameter logic [7:0]  CFG_MSB     = 8'hC2,
   parameter logic [7:0]  CFG_LSB     = 8'hE3,
   parameter int unsigned TIMEOUT_CYC = 200000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        i2c_ena,
   output logic [6:0]  i2c_addr,
   output logic        i2c_rw,
   output logic [7:0]  i2c_data_wr,
   input  logic        i2c_busy,
   input  logic [7:0]  i2c_data_rd,
   input  logic        i2c_ack_error,
   output logic [11:0] sample,
   output logic        sample_valid,
   output logic        cfg_done,
   output logic        overrun,
   output logic        error
);

   localparam int unsigned Div  = CLK_HZ / SAMPLE_HZ;
   localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;
   localparam int unsigned WdW  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      StIdle, StCfg, StPtr, StWait, StRead, StFilt, StOut, StErr
   } state_e;

   state_e            state_q, state_d;
   logic              busy_prev_q;
   logic [1:0]        busy_cnt_q, busy_cnt_d;
   logic [WdW-1:0]    wd_q, wd_d;
   logic [DivW-1:0]   div_q, div_d;
   logic              pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic              cfg_done_q, cfg_done_d;
   logic [7:0]        msb_q, msb_d;
   logic [11:0]       sample_q, sample_d;

   logic              rise, fall, tick, consume, in_xfer;
   logic [11:0]       raw;

   // Low nibble of the LSB byte is padding from the ADC.
   logic              unused_rd_lo;
   assign unused_rd_lo = ^i2c_data_rd[3:0];

   assign rise    = i2c_busy & ~busy_prev_q;
   assign fall    = ~i2c_busy & busy_prev_q;
   assign tick    = cfg_done_q && (div_q == DivW'(Div - 1));
   assign consume = (state_q == StWait) && pending_q;
   assign in_xfer = (state_q == StCfg) || (state_q == StPtr) || (state_q == StRead);
   assign raw     = {msb_q, i2c_data_rd[7:4]};

`ifdef ADC_DCBLOCK_EN
   logic signed [17:0] acc_q, acc_d;
   logic [11:0]        raw_q, raw_d;
   logic signed [17:0] dc_diff;
   logic [11:0]        dc_sat;

   // acc tracks the DC level scaled by 64; the output is x minus that level.
   always_comb begin
      dc_diff = $signed({{6{raw_q[11]}}, raw_q}) - (acc_q >>> 6);
      if (dc_diff > 18'sd2047) begin
         dc_sat = 12'h7FF;
      end else if (dc_diff < -18'sd2048) begin
         dc_sat = 12'h800;
      end else begin
         dc_sat = dc_diff[11:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
         raw_q <= '0;
      end else begin
         acc_q <= acc_d;
         raw_q <= raw_d;
      end
   end
`endif

   // Next-state, sequencing and datapath updates.
   always_comb begin
      state_d    = state_q;
      cfg_done_d = cfg_done_q;
      msb_d      = msb_q;
      sample_d   = sample_q;
`ifdef ADC_DCBLOCK_EN
      acc_d      = acc_q;
      raw_d      = raw_q;
`endif

      case (state_q)
         StIdle: begin
            if (enable && !i2c_busy) state_d = StCfg;
         end
         StCfg: begin
            if (fall) begin
               if (i2c_ack_error)            state_d = StErr;
               else if (busy_cnt_q == 2'd3)  state_d = StPtr;
            end
         end
         StPtr: begin
            if (fall) begin
               if (i2c_ack_error) begin
                  state_d = StErr;
               end else begin
                  cfg_done_d = 1'b1;
                  state_d    = StWait;
               end
            end
         end
         StWait: begin
            if (pending_q) state_d = StRead;
         end
         StRead: begin
            // Second rise: the first data byte has landed in the master.
            if (rise && (busy_cnt_q == 2'd1)) msb_d = i2c_data_rd;
            if (fall) begin
               if (i2c_ack_error) begin
                  state_d = StErr;
               end else if (busy_cnt_q == 2'd2) begin
`ifdef ADC_DCBLOCK_EN
                  raw_d   = raw;
                  state_d = StFilt;
`else
                  sample_d = raw;
                  state_d  = StOut;
`endif
               end
            end
         end
`ifdef ADC_DCBLOCK_EN
         StFilt: begin
            acc_d    = acc_q + dc_diff;
            sample_d = dc_sat;
            state_d  = StOut;
         end
`endif
         StOut:   state_d = StWait;
         StErr:   state_d = StErr;
         default: state_d = StIdle;
      endcase

      if (in_xfer && (wd_q == WdW'(TIMEOUT_CYC - 1))) state_d = StErr;
      if (state_d == StErr) cfg_done_d = 1'b0;

      if (!enable) begin
         state_d    = StIdle;
         cfg_done_d = 1'b0;
`ifdef ADC_DCBLOCK_EN
         acc_d      = '0;
`endif
      end

      // Rise counter and watchdog restart on entry to every transaction state.
      if (state_d != state_q) begin
         busy_cnt_d = 2'd0;
         wd_d       = '0;
      end else begin
         busy_cnt_d = (rise && (busy_cnt_q != 2'd3)) ? busy_cnt_q + 2'd1 : busy_cnt_q;
         wd_d       = in_xfer ? wd_q + WdW'(1) : '0;
      end

      if (!cfg_done_q || (div_q == DivW'(Div - 1))) div_d = '0;
      else                                           div_d = div_q + DivW'(1);

      // A tick that lands on a consume keeps pending set; a tick on an
      // unconsumed pending is dropped and flagged.
      pending_d = pending_q & ~consume;
      overrun_d = overrun_q;
      if (tick) begin
         if (pending_q && !consume) overrun_d = 1'b1;
         pending_d = 1'b1;
      end
      if (!enable) begin
         pending_d = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         busy_prev_q <= 1'b0;
         busy_cnt_q  <= 2'd0;
         wd_q        <= '0;
         div_q       <= '0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         cfg_done_q  <= 1'b0;
         msb_q       <= 8'h00;
         sample_q    <= 12'h000;
      end else begin
         state_q     <= state_d;
         busy_prev_q <= i2c_busy;
         busy_cnt_q  <= busy_cnt_d;
         wd_q        <= wd_d;
         div_q       <= div_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         cfg_done_q  <= cfg_done_d;
         msb_q       <= msb_d;
         sample_q    <= sample_d;
      end
   end

   // Command outputs decoded from the state and the rise count.
   always_comb begin
      i2c_ena     = 1'b0;
      i2c_rw      = 1'b0;
      i2c_data_wr = 8'h00;
      case (state_q)
         StCfg: begin
            i2c_ena = (busy_cnt_q != 2'd3);
            case (busy_cnt_q)
               2'd0:    i2c_data_wr = 8'h01;
               2'd1:    i2c_data_wr = CFG_MSB;
               default: i2c_data_wr = CFG_LSB;
            endcase
         end
         StPtr: begin
            i2c_ena = (busy_cnt_q == 2'd0);
         end
         StRead: begin
            i2c_ena = (busy_cnt_q < 2'd2);
            i2c_rw  = 1'b1;
         end
         default: ;
      endcase
      // Dropping enable releases the master at once.
      if (!enable) i2c_ena = 1'b0;
   end

   assign i2c_addr     = DEV_ADDR;
   assign sample       = sample_q;
   assign sample_valid = (state_q == StOut) && enable;
   assign cfg_done     = cfg_done_q;
   assign overrun      = overrun_q;
   assign error        = (state_q == StErr);

endmodule
